// File: rtl/handshake_fifo.sv
// Valid/ready elastic buffer with occupancy reporting and synchronous flush.
// Define HANDSHAKE_FIFO_BYPASS_EN to enable the zero-latency empty-buffer bypass.
module handshake_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [DATA_W-1:0]          data_o,
  input  logic                       ready_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wrPtr;
  logic [PW-1:0]     r_rdPtr;
  logic              r_ready;

  logic              w_empty;
  logic              w_full;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic [PW-1:0]     w_wrPtrNext;
  logic [PW-1:0]     w_rdPtrNext;
  logic [PW-1:0]     w_countNext;
  logic [DATA_W-1:0] w_rdData;

  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) && (r_wrPtr[AW] != r_rdPtr[AW]);

`ifdef HANDSHAKE_FIFO_BYPASS_EN
  // r_ready guards the cycle right after reset, when the word could not be accepted.
  assign w_bypass = w_empty && !flush_i && valid_i && ready_i && r_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign ready_o = r_ready && !flush_i;
  assign valid_o = !flush_i && (!w_empty || w_bypass);

  // A bypassed word is both pushed and popped without touching storage.
  assign w_push = valid_i && ready_o && !w_bypass;
  assign w_pop  = valid_o && ready_i && !w_bypass;

  assign w_wrPtrNext = r_wrPtr + PW'(w_push);
  assign w_rdPtrNext = flush_i ? r_wrPtr : (r_rdPtr + PW'(w_pop));
  assign w_countNext = w_wrPtrNext - w_rdPtrNext;

  assign w_rdData = r_mem[r_rdPtr[AW-1:0]];
  assign data_o   = !valid_o ? '0 : (w_bypass ? data_i : w_rdData);

  assign count_o = r_wrPtr - r_rdPtr;
  assign full_o  = w_full;
  assign empty_o = w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_ready <= 1'b0;
    end else begin
      r_wrPtr <= w_wrPtrNext;
      r_rdPtr <= w_rdPtrNext;
      r_ready <= (w_countNext != PW'(DEPTH));
    end
  end

  // Storage is deliberately not reset; data_o masking hides stale entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: tb/tb_handshake_fifo.sv
// Self-checking bench for handshake_fifo: queue-based reference model, directed
// scenarios with literal pins, then randomized traffic with flushes.
module tb_handshake_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_o;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic              ready_i;
  logic              flush_i;
  logic [CW-1:0]     count_o;
  logic              full_o;
  logic              empty_o;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mQueue[$];
  bit                mReady;
  bit                expValid;
  bit                expReady;
  bit                expBypass;

  handshake_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
    .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
    .flush_i(flush_i), .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs follow from the queue contents and current inputs.
  task automatic checkOutput();
    logic [DATA_W-1:0] expData;
    int sz;
    sz = mQueue.size();
`ifdef HANDSHAKE_FIFO_BYPASS_EN
    expBypass = (sz == 0) && !flush_i && valid_i && ready_i && mReady;
`else
    expBypass = 1'b0;
`endif
    expValid = !flush_i && ((sz > 0) || expBypass);
    expReady = mReady && !flush_i;
    expData  = '0;
    if (expValid) expData = (sz > 0) ? mQueue[0] : data_i;
    compare("valid_o", 32'(valid_o), 32'(expValid));
    compare("data_o", 32'(data_o), 32'(expData));
    compare("ready_o", 32'(ready_o), 32'(expReady));
    compare("count_o", 32'(count_o), sz);
    compare("full_o", 32'(full_o), 32'(sz == DEPTH));
    compare("empty_o", 32'(empty_o), 32'(sz == 0));
  endtask

  task automatic updateModel();
    if (flush_i) begin
      mQueue.delete();
    end else if (!expBypass) begin
      if (expValid && ready_i) void'(mQueue.pop_front());
      if (valid_i && expReady) mQueue.push_back(data_i);
    end
    mReady = (mQueue.size() != DEPTH);
  endtask

  task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit f);
    @(negedge clk);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    #1;
    checkOutput();
    @(posedge clk);
    updateModel();
    #2;
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    ready_i = 1'b0;
    flush_i = 1'b0;
    mReady  = 1'b0;
    #1;
    compare("reset valid_o", 32'(valid_o), 0);
    compare("reset data_o", 32'(data_o), 0);
    compare("reset ready_o", 32'(ready_o), 0);
    compare("reset count_o", 32'(count_o), 0);
    compare("reset empty_o", 32'(empty_o), 1);
    compare("reset full_o", 32'(full_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare("ready before first edge", 32'(ready_o), 0);
    @(posedge clk);
    #1;
    compare("ready after first edge", 32'(ready_o), 1);
    mReady = 1'b1;

    // Single word through an idle buffer.
    applyStimulus(1, 8'hA5, 1, 0);
    compare("A5 valid", 32'(valid_o), 1);
    compare("A5 data", 32'(data_o), 32'h A5);
    applyStimulus(0, 8'h00, 1, 0);
    compare("A5 drained count", 32'(count_o), 0);

    // Fill under backpressure, refuse a fifth word, then pop at full.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 8'(i), 0, 0);
      compare("fill count", 32'(count_o), i);
    end
    compare("fill full_o", 32'(full_o), 1);
    compare("fill ready_o", 32'(ready_o), 0);
    applyStimulus(1, 8'h05, 0, 0);
    compare("refused count", 32'(count_o), 4);
    applyStimulus(1, 8'h05, 1, 0);
    compare("pop at full count", 32'(count_o), 3);
    compare("pop at full ready", 32'(ready_o), 1);
    compare("pop at full next data", 32'(data_o), 32'h02);
    applyStimulus(1, 8'h05, 0, 0);
    compare("retry accepted count", 32'(count_o), 4);
    for (int i = 0; i < 5; i++) applyStimulus(0, 8'h00, 1, 0);
    compare("drained empty", 32'(empty_o), 1);

    // Steady state at occupancy two across several pointer wraps.
    applyStimulus(1, 8'h10, 0, 0);
    applyStimulus(1, 8'h11, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 8'(8'h12 + i), 1, 0);
      compare("steady count", 32'(count_o), 2);
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0);

    // Flush with three words stored and an upstream word pending.
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'h60 + i), 0, 0);
    applyStimulus(1, 8'h77, 1, 1);
    compare("flush count", 32'(count_o), 0);
    compare("flush empty", 32'(empty_o), 1);
    compare("flush ready masked", 32'(ready_o), 0);
    compare("flush valid masked", 32'(valid_o), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0);

    // Asynchronous reset with two words stored.
    applyStimulus(1, 8'h21, 0, 0);
    applyStimulus(1, 8'h22, 0, 0);
    @(negedge clk);
    valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    compare("midreset valid_o", 32'(valid_o), 0);
    compare("midreset count_o", 32'(count_o), 0);
    compare("midreset ready_o", 32'(ready_o), 0);
    mQueue.delete();
    mReady = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare("post-reset ready", 32'(ready_o), 1);
    mReady = 1'b1;
    applyStimulus(1, 8'h3C, 0, 0);
    compare("3C first out", 32'(data_o), 32'h3C);
    applyStimulus(0, 8'h00, 1, 0);
    compare("3C drained", 32'(empty_o), 1);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(bit'($urandom_range(0, 99) < 60), 8'($urandom),
                    bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
